l3_bus_controller: RTL and testbench
====================================

Name: l3_bus_controller

Overview:
Sequencer and arbiter for the shared L3 split-transaction bus that connects the four per-core L1/L2 units to the shared L3.
- Grants the bus round-robin to one requesting core.
- Sequences each transaction as address phase, snoop phase, data beats (word0..word3), then done.
- Collects MESI share responses from the snooping cores and tags every bus cycle with phase and source, so receivers can tell address from data.

Parameters:
NUM_REQ, 4, number of requesting cores (processor-ID width = $clog2(NUM_REQ))
ADDR_W, 32, line address width driven on the bus (processor ID carried separately on bus_src)
BEATS, 4, data words per line transfer (128-bit line / 32-bit word)

Ports:
clk  in  1  clock; rising edge only
rstN  in  1  synchronous active-low reset
req  in  NUM_REQ  per-core bus request; level, held until done pulse
cmd_i  in  2*NUM_REQ  per-core command: 0=GETS, 1=GETX, 2=INV, 3=PUTX
addr_i  in  ADDR_W*NUM_REQ  per-core line address
share_i  in  NUM_REQ  per-core snoop "I hold a copy" response, sampled in SNOOP
mem_ready  in  1  L3 accepts/supplies current data beat this cycle
grant  out  NUM_REQ  one-hot owner, held for whole transaction
bus_valid  out  1  bus carries a valid phase
bus_tag  out  2  0=IDLE, 1=ADDR, 2=SNOOP, 3=DATA
bus_src  out  2  processor ID of owner
bus_cmd  out  2  latched command of owner
bus_addr  out  ADDR_W  latched address of owner
beat_idx  out  2  current data word index
shared_o  out  1  OR of share_i excluding owner, latched
done  out  NUM_REQ  one-cycle completion pulse to owner

Behaviour:
- Reset (rstN=0 at a clock edge): state IDLE, rr pointer=0.
  - All outputs 0; bus_tag=IDLE.
  - Applies mid-transaction too: the transfer is abandoned, no done pulse, pointer returns to 0.
- All outputs are registered. State machine: IDLE, ADDR, SNOOP, DATA, DONE.
- IDLE:
  - If req!=0, pick the first set bit at or after the pointer (wrapping mod NUM_REQ).
  - Latch grant, bus_src, cmd, addr; go to ADDR.
  - The request sampled at edge t shows ADDR at cycle t+1.
- ADDR, 1 cycle: bus_valid=1, tag=ADDR. Go to SNOOP.
- SNOOP, 1 cycle:
  - shared_o <= |(share_i & ~grant).
  - Go to DATA if cmd is GETS, GETX or PUTX; go to DONE if cmd is INV.
- DATA, BEATS beats:
  - tag=DATA, beat_idx starts at 0.
  - A beat completes on a cycle with mem_ready=1; beat_idx increments.
  - mem_ready=0 holds beat_idx and all bus outputs.
  - Completion of beat BEATS-1 goes to DONE. beat_idx never wraps within a transaction.
- DONE, 1 cycle:
  - done[owner]=1, bus_valid=0.
  - Pointer <= owner+1 mod NUM_REQ.
  - Go to IDLE; grant, shared_o and beat_idx clear in IDLE.
- Request and grant rules:
  - Changes to req, cmd_i or addr_i after the IDLE grant are ignored until DONE; the owner dropping req mid-transfer does not abort.
  - A core still requesting after its done pulse is re-arbitrated normally.
  - Back-to-back transactions: minimum one IDLE cycle between DONE and the next ADDR.
- Simultaneous requests: exactly one grant. Starvation-free; worst-case wait is NUM_REQ-1 transactions.
- Nominal latency with mem_ready=1: GETS/GETX/PUTX = 7 cycles from req sample to done pulse; INV = 3.

Decomposition:
- Package l3_bus_pkg holds:
  - bus_cmd_e (GETS/GETX/INV/PUTX)
  - bus_tag_e (IDLE/ADDR/SNOOP/DATA)
  - ctrl_state_e
  - BEATS and LINE_W=128 constants
- One sub-module, l3_rr_pick: combinational priority pick from req and pointer, returning a one-hot grant and an ID. The pointer register stays in the top level.

Test Plan:
- req=0001, GETS, addr 0x0000_1000, mem_ready=1 -> the cycle after sampling:
  - ADDR with bus_addr=0x1000, src=0; then SNOOP.
  - DATA with beat_idx 0,1,2,3; then done=0001 exactly 7 cycles after sampling.
- req=1111 held continuously, all GETX -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by full transactions and no overlapping grants.
- GETS from P0, mem_ready low 3 cycles while beat_idx=1 -> beat_idx holds at 1, bus outputs stable, done arrives 3 cycles later (cycle 10).
- INV from P2, addr 0xABCD_0000 -> ADDR, SNOOP, DONE with no DATA tag, done=0100 at cycle 3.
- GETS from P1, share_i=0101 in SNOOP -> shared_o=1 through DONE. Repeat with share_i=0010 (owner only) -> shared_o=0.
- rstN=0 during DATA beat 2 of P3, then req=1001 -> all outputs 0 the cycle after reset, no done pulse, and P0 is granted first (pointer=0).

Source files
------------

// File: rtl/l3_bus_controller_pkg.sv
// Shared types and constants for the L3 split-transaction bus controller.
package l3_bus_pkg;

    localparam int BEATS  = 4;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        CMD_GETS = 2'd0,
        CMD_GETX = 2'd1,
        CMD_INV  = 2'd2,
        CMD_PUTX = 2'd3
    } bus_cmd_e;

    typedef enum logic [1:0] {
        TAG_IDLE  = 2'd0,
        TAG_ADDR  = 2'd1,
        TAG_SNOOP = 2'd2,
        TAG_DATA  = 2'd3
    } bus_tag_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_SNOOP = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/l3_bus_controller_if.sv
// Core/L3 side of the shared bus: per-core requests in, tagged bus cycles and grants out.
interface l3_bus_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      cmd_i;
    logic [ADDR_W*NUM_REQ-1:0] addr_i;
    logic [NUM_REQ-1:0]        share_i;
    logic                      mem_ready;

    logic [NUM_REQ-1:0]        grant;
    logic                      bus_valid;
    logic [1:0]                bus_tag;
    logic [ID_W-1:0]           bus_src;
    logic [1:0]                bus_cmd;
    logic [ADDR_W-1:0]         bus_addr;
    logic [1:0]                beat_idx;
    logic                      shared_o;
    logic [NUM_REQ-1:0]        done;

    modport master (
        input  req, cmd_i, addr_i, share_i, mem_ready,
        output grant, bus_valid, bus_tag, bus_src, bus_cmd, bus_addr,
               beat_idx, shared_o, done
    );

    modport slave (
        output req, cmd_i, addr_i, share_i, mem_ready,
        input  grant, bus_valid, bus_tag, bus_src, bus_cmd, bus_addr,
               beat_idx, shared_o, done
    );

endinterface

// File: rtl/l3_bus_controller_rr_pick.sv
// Round-robin pick: first requester at or after ptr, wrapping.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
// Exactly one gnt bit set whenever vld is high.
module l3_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               vld
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt = '0;
        id  = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!vld && req[idx]) begin
                vld      = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/l3_bus_controller.sv
// Arbiter/sequencer for the shared L3 bus: ADDR, SNOOP, DATA beats, DONE per transaction.
// Latency: 7 cycles req-sample to done (3 for INV) with mem_ready high; all outputs registered.
// Backpressure: mem_ready low stalls the current data beat and freezes every bus output.
module l3_bus_controller #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int BEATS   = l3_bus_pkg::BEATS
) (
    input  logic     clk,
    input  logic     rstN,
    l3_bus_if.master bus
);
    import l3_bus_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    ctrl_state_e          state;
    logic [ID_W-1:0]      ptr;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 valid_q;
    bus_tag_e             tag_q;
    logic [ID_W-1:0]      src_q;
    bus_cmd_e             cmd_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [1:0]           beat_q;
    logic                 shared_q;
    logic [NUM_REQ-1:0]   done_q;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_vld;
    logic [1:0]           sel_cmd;
    logic [ADDR_W-1:0]    sel_addr;

    l3_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .id  (pick_id),
        .vld (pick_vld)
    );

    // Mux the winner's command/address out of the flattened per-core buses.
    always_comb begin
        sel_cmd  = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_cmd  = bus.cmd_i[2*i +: 2];
                sel_addr = bus.addr_i[ADDR_W*i +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            tag_q    <= TAG_IDLE;
            src_q    <= '0;
            cmd_q    <= CMD_GETS;
            addr_q   <= '0;
            beat_q   <= '0;
            shared_q <= 1'b0;
            done_q   <= '0;
        end else begin
            done_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_gnt;
                        src_q   <= pick_id;
                        cmd_q   <= bus_cmd_e'(sel_cmd);
                        addr_q  <= sel_addr;
                        valid_q <= 1'b1;
                        tag_q   <= TAG_ADDR;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    tag_q <= TAG_SNOOP;
                    state <= ST_SNOOP;
                end
                ST_SNOOP: begin
                    // The owner's own share bit is meaningless for its request.
                    shared_q <= |(bus.share_i & ~grant_q);
                    if (cmd_q == CMD_INV) begin
                        valid_q <= 1'b0;
                        tag_q   <= TAG_IDLE;
                        done_q  <= grant_q;
                        state   <= ST_DONE;
                    end else begin
                        tag_q <= TAG_DATA;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.mem_ready) begin
                        if (beat_q == 2'(BEATS-1)) begin
                            valid_q <= 1'b0;
                            tag_q   <= TAG_IDLE;
                            done_q  <= grant_q;
                            state   <= ST_DONE;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    ptr      <= (src_q == ID_W'(NUM_REQ-1)) ? '0 : src_q + 1'b1;
                    grant_q  <= '0;
                    shared_q <= 1'b0;
                    beat_q   <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_tag   = tag_q;
    assign bus.bus_src   = src_q;
    assign bus.bus_cmd   = cmd_q;
    assign bus.bus_addr  = addr_q;
    assign bus.beat_idx  = beat_q;
    assign bus.shared_o  = shared_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_l3_bus_controller.sv
// Directed bench for l3_bus_controller: arbitration order, phase sequencing, stalls, snoop, reset.
module tb_l3_bus_controller;
    import l3_bus_pkg::*;

    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    l3_bus_if #(.NUM_REQ(4), .ADDR_W(32)) bus ();

    l3_bus_controller #(
        .NUM_REQ (4),
        .ADDR_W  (32),
        .BEATS   (4)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input string name, input logic vld, input logic [1:0] tag,
                         input logic [3:0] gnt, input logic [3:0] dn, input logic [1:0] beat);
        check({name, ".valid"}, 32'(bus.bus_valid), 32'(vld));
        check({name, ".tag"},   32'(bus.bus_tag),   32'(tag));
        check({name, ".grant"}, 32'(bus.grant),     32'(gnt));
        check({name, ".done"},  32'(bus.done),      32'(dn));
        check({name, ".beat"},  32'(bus.beat_idx),  32'(beat));
    endtask

    // One full data transaction with mem_ready high; the first step lands on ADDR.
    task automatic run_line(input string name, input logic [3:0] g, input logic [1:0] src,
                            input logic [31:0] addr, input logic drop,
                            input logic [3:0] share, input logic exp_sh);
        for (int c = 1; c <= 8; c++) begin
            step();
            case (c)
                1: begin
                    phase($sformatf("%s.c1", name), 1'b1, TAG_ADDR, g, 4'b0, 2'd0);
                    check({name, ".src"},  32'(bus.bus_src), 32'(src));
                    check({name, ".addr"}, bus.bus_addr, addr);
                    if (drop) bus.req = 4'b0;
                end
                2: begin
                    phase($sformatf("%s.c2", name), 1'b1, TAG_SNOOP, g, 4'b0, 2'd0);
                    bus.share_i = share;
                end
                3, 4, 5, 6: begin
                    phase($sformatf("%s.c%0d", name, c), 1'b1, TAG_DATA, g, 4'b0, 2'(c-3));
                    if (c == 3) begin
                        check({name, ".shared_data"}, 32'(bus.shared_o), 32'(exp_sh));
                        bus.share_i = 4'b0;
                    end
                end
                7: begin
                    phase($sformatf("%s.c7", name), 1'b0, TAG_IDLE, g, g, 2'd3);
                    check({name, ".shared_done"}, 32'(bus.shared_o), 32'(exp_sh));
                end
                default: begin
                    phase($sformatf("%s.c8", name), 1'b0, TAG_IDLE, 4'b0, 4'b0, 2'd0);
                    check({name, ".shared_idle"}, 32'(bus.shared_o), 32'd0);
                end
            endcase
        end
    endtask

    initial begin
        logic [31:0] a2 [4];
        rstN          = 1'b0;
        bus.req       = '0;
        bus.cmd_i     = '0;
        bus.addr_i    = '0;
        bus.share_i   = '0;
        bus.mem_ready = 1'b0;

        // Reset state
        step();
        step();
        phase("reset", 1'b0, TAG_IDLE, 4'b0, 4'b0, 2'd0);
        check("reset.addr",   bus.bus_addr, 32'd0);
        check("reset.shared", 32'(bus.shared_o), 32'd0);

        // GETS from P0, nominal 7-cycle line
        rstN          = 1'b1;
        bus.req       = 4'b0001;
        bus.cmd_i     = 8'h00;
        bus.addr_i    = {32'h0, 32'h0, 32'h0, 32'h0000_1000};
        bus.mem_ready = 1'b1;
        run_line("gets_p0", 4'b0001, 2'd0, 32'h0000_1000, 1'b1, 4'b0, 1'b0);
        check("gets_p0.cmd", 32'(bus.bus_cmd), 32'(CMD_GETS));

        // All four request GETX continuously: rotation from pointer 0
        rstN = 1'b0;
        step();
        rstN       = 1'b1;
        a2         = '{32'h0000_0A00, 32'h1111_0B00, 32'h2222_0C00, 32'h3333_0D00};
        bus.addr_i = {a2[3], a2[2], a2[1], a2[0]};
        bus.cmd_i  = 8'h55;
        bus.req    = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_line($sformatf("rr%0d", k), 4'(1 << (k % 4)), 2'(k % 4), a2[k % 4],
                     (k == 4), 4'b0, 1'b0);
        end

        // GETS P0 with a three-cycle stall at beat 1; pointer sits at 1 so P0 wins by wrap
        bus.req    = 4'b0001;
        bus.cmd_i  = 8'h00;
        bus.addr_i = {32'h0, 32'h0, 32'h0, 32'h0000_2000};
        step();
        phase("stall.c1", 1'b1, TAG_ADDR, 4'b0001, 4'b0, 2'd0);
        bus.req = 4'b0;
        step();
        phase("stall.c2", 1'b1, TAG_SNOOP, 4'b0001, 4'b0, 2'd0);
        step();
        phase("stall.c3", 1'b1, TAG_DATA, 4'b0001, 4'b0, 2'd0);
        step();
        phase("stall.c4", 1'b1, TAG_DATA, 4'b0001, 4'b0, 2'd1);
        bus.mem_ready = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            step();
            phase($sformatf("stall.c%0d", c), 1'b1, TAG_DATA, 4'b0001, 4'b0, 2'd1);
            check($sformatf("stall.c%0d.addr", c), bus.bus_addr, 32'h0000_2000);
        end
        bus.mem_ready = 1'b1;
        step();
        phase("stall.c8", 1'b1, TAG_DATA, 4'b0001, 4'b0, 2'd2);
        step();
        phase("stall.c9", 1'b1, TAG_DATA, 4'b0001, 4'b0, 2'd3);
        step();
        phase("stall.c10", 1'b0, TAG_IDLE, 4'b0001, 4'b0001, 2'd3);
        step();
        phase("stall.c11", 1'b0, TAG_IDLE, 4'b0, 4'b0, 2'd0);

        // INV from P2: no data phase
        bus.req    = 4'b0100;
        bus.cmd_i  = 8'h20;
        bus.addr_i = {32'h0, 32'hABCD_0000, 32'h0, 32'h0};
        step();
        phase("inv.c1", 1'b1, TAG_ADDR, 4'b0100, 4'b0, 2'd0);
        check("inv.src",  32'(bus.bus_src), 32'd2);
        check("inv.addr", bus.bus_addr, 32'hABCD_0000);
        check("inv.cmd",  32'(bus.bus_cmd), 32'(CMD_INV));
        bus.req = 4'b0;
        step();
        phase("inv.c2", 1'b1, TAG_SNOOP, 4'b0100, 4'b0, 2'd0);
        step();
        phase("inv.c3", 1'b0, TAG_IDLE, 4'b0100, 4'b0100, 2'd0);
        step();
        phase("inv.c4", 1'b0, TAG_IDLE, 4'b0, 4'b0, 2'd0);

        // GETS from P1 with other sharers, then with only the owner's own bit set
        bus.req    = 4'b0010;
        bus.cmd_i  = 8'h00;
        bus.addr_i = {32'h0, 32'h0, 32'h0000_3040, 32'h0};
        run_line("share", 4'b0010, 2'd1, 32'h0000_3040, 1'b1, 4'b0101, 1'b1);
        bus.req = 4'b0010;
        run_line("share_own", 4'b0010, 2'd1, 32'h0000_3040, 1'b1, 4'b0010, 1'b0);

        // Reset during beat 2 of a P3 line
        bus.req    = 4'b1000;
        bus.addr_i = {32'h0000_5000, 32'h0, 32'h0, 32'h0000_6000};
        step();
        phase("rst_mid.c1", 1'b1, TAG_ADDR, 4'b1000, 4'b0, 2'd0);
        check("rst_mid.src", 32'(bus.bus_src), 32'd3);
        for (int c = 2; c <= 5; c++) step();
        phase("rst_mid.c5", 1'b1, TAG_DATA, 4'b1000, 4'b0, 2'd2);
        rstN    = 1'b0;
        bus.req = 4'b1001;
        step();
        phase("rst_mid.after", 1'b0, TAG_IDLE, 4'b0, 4'b0, 2'd0);
        check("rst_mid.addr", bus.bus_addr, 32'd0);
        check("rst_mid.src0", 32'(bus.bus_src), 32'd0);
        rstN = 1'b1;
        run_line("post_rst", 4'b0001, 2'd0, 32'h0000_6000, 1'b1, 4'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
